// File: rtl/seq_cla_pkg.sv
// seq_cla_pkg: shared FSM state and result-flag types for the sequential add/sub unit
package seq_cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder (a,b,cin in; sum,cout,c_msb out)
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [SLICE-1:0] g, p;
  logic [SLICE:0] c;
  logic gg, pp;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c = '0;
    gg = 1'b0;
    pp = 1'b1;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gg = gg | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & cin);
    end
  end
  assign sum = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

// File: rtl/seq_cla_addsub.sv
// seq_cla_addsub: slice-per-cycle CLA add/sub with valid/ready (a,b,op_sub in; result,cout,ovf,zero,neg out)
module seq_cla_addsub
  import seq_cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t state;
  flags_t flg;
  logic [WIDTH-1:0] opa, opb, res_q, res_d;
  logic [CW-1:0] cnt;
  logic carry, last;
  logic [SLICE-1:0] s_sum;
  logic s_cout, s_cmsb;
  cla_slice #(.SLICE(SLICE)) u_slice (
    .a(opa[cnt*SLICE +: SLICE]),
    .b(opb[cnt*SLICE +: SLICE]),
    .cin(carry),
    .sum(s_sum),
    .cout(s_cout),
    .c_msb(s_cmsb)
  );
  assign last = cnt == CW'(NSLICE - 1);
  always_comb begin
    res_d = res_q;
    res_d[cnt*SLICE +: SLICE] = s_sum;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      opa <= '0;
      opb <= '0;
      carry <= 1'b0;
      cnt <= '0;
      res_q <= '0;
      flg <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa <= a;
          opb <= op_sub ? ~b : b;
          carry <= op_sub;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          res_q <= res_d;
          carry <= s_cout;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            flg <= '{cout: s_cout, ovf: s_cout ^ s_cmsb, zero: res_d == '0, neg: res_d[WIDTH-1]};
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign result = res_q;
  assign {cout, ovf, zero, neg} = flg;
endmodule

// File: tb/tb_seq_cla_addsub.sv
// tb_seq_cla_addsub: scoreboard bench for seq_cla_addsub at WIDTH=8 and WIDTH=16
module tb_seq_cla_addsub;
  localparam int W = 8, NS = W / 4, W2 = 16, NS2 = W2 / 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, op_sub = 0, out_ready = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid, cout, ovf, zero, neg;
  logic [W-1:0] result;
  logic in_valid2 = 0, op_sub2 = 0, out_ready2 = 1;
  logic [W2-1:0] a2 = 0, b2 = 0;
  logic in_ready2, out_valid2, cout2, ovf2, zero2, neg2;
  logic [W2-1:0] result2;
  seq_cla_addsub #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );
  seq_cla_addsub #(.WIDTH(W2), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .op_sub(op_sub2), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .cout(cout2), .ovf(ovf2), .zero(zero2), .neg(neg2)
  );
  int compared = 0, mismatched = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [19:0] exp;
    int acc;
  } item_t;
  item_t q[$];
  logic prev_ov = 0;
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic s, input int w);
    logic [31:0] m, bb, t;
    logic [15:0] r;
    m = (32'd1 << w) - 1;
    bb = s ? (~{16'b0, y}) & m : {16'b0, y};
    t = {16'b0, x} + bb + {31'b0, s};
    r = t[15:0] & m[15:0];
    return {r, t[w], (x[w-1] == bb[w-1]) && (r[w-1] != x[w-1]), r == 16'd0, r[w-1]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 0;
    end else begin
      if (in_valid && in_ready) q.push_back('{model({8'b0, a}, {8'b0, b}, op_sub, W), cyc});
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          if (!prev_ov) check("latency", cyc - q[0].acc, NS + 1);
          check("result", result, q[0].exp[11:4]);
          check("flags", {cout, ovf, zero, neg}, q[0].exp[3:0]);
          check("in_ready_in_done", in_ready, 0);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s);
    bit ok;
    ok = 0;
    @(posedge clk) #1;
    a = x; b = y; op_sub = s; in_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk) #1;
    in_valid = 0;
  endtask
  task automatic drain();
    bit ok;
    ok = 0;
    out_ready = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && q.size() == 0;
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic s);
    int k;
    bit got;
    logic [19:0] e;
    e = model(x, y, s, 16);
    @(posedge clk) #1;
    a2 = x; b2 = y; op_sub2 = s; in_valid2 = 1;
    @(negedge clk);
    check("in_ready16", in_ready2, 1);
    k = cyc;
    @(posedge clk) #1;
    in_valid2 = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid2;
    end
    if (!got) check("timeout16", 0, 1);
    else begin
      check("latency16", cyc - k, NS2 + 1);
      check("result16", result2, e[19:4]);
      check("flags16", {cout2, ovf2, zero2, neg2}, e[3:0]);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {out_valid, result, cout, ovf, zero, neg}, 0);
    check("rst_outs16", {out_valid2, result2, cout2, ovf2, zero2, neg2}, 0);
    @(posedge clk) #1;
    rst_n = 1;
    out_ready = 1;
    issue(8'h7F, 8'h01, 0);
    issue(8'h05, 8'h05, 1);
    issue(8'h03, 8'h05, 1);
    issue(8'hFF, 8'h01, 0);
    drain();
    out_ready = 0;
    issue(8'h12, 8'h34, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      in_valid = 1; a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
    end
    @(posedge clk) #1;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_consume", in_ready, 1);
    check("out_valid_after_consume", out_valid, 0);
    issue(8'h55, 8'h66, 0);
    @(posedge clk) #1;
    rst_n = 0;
    @(posedge clk) #1;
    rst_n = 1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_outs", {out_valid, result, cout, ovf, zero, neg}, 0);
    issue(8'h10, 8'h20, 0);
    drain();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk) #1;
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 4) == 0 ? 8'h80 : 8'($urandom);
      b = $urandom_range(0, 4) == 0 ? 8'hFF : 8'($urandom);
      op_sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk) #1;
    in_valid = 0;
    drain();
    run16(16'h8000, 16'h0001, 1);
    run16(16'hFFFF, 16'h0001, 0);
    run16(16'h7FFF, 16'h0001, 0);
    for (int i = 0; i < 8; i++) run16(16'($urandom), 16'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_cla_addsub.md
Name: seq_cla_addsub

Overview:
Multi-cycle, parametrised add/subtract unit for the calculator arithmetic path. It processes a WIDTH-bit operand pair one SLICE-bit carry-lookahead slice per cycle, LSB slice first, and registers the carry between slices. A valid/ready handshake sits on both sides, and the unit reports carry/borrow, signed overflow, zero and negative flags. It replaces fixed 4-bit combinational adders wherever wider operands or subtraction are needed.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of SLICE and at least SLICE.
SLICE, 4, bits processed per cycle by the lookahead slice.
NSLICE (localparam), WIDTH/SLICE, number of slice cycles per operation.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  operands and op_sub are valid.
in_ready  out  1  unit can accept an operation; high only in IDLE.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
op_sub  in  1  0: A+B, carry-in 0; 1: A−B, computed as A + ~B with carry-in 1.
out_valid  out  1  result and flags are valid.
out_ready  in  1  consumer accepts the result.
result  out  WIDTH  sum or difference, modulo 2^WIDTH.
cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
ovf  out  1  signed overflow = (carry into MSB) XOR (carry out of MSB).
zero  out  1  result == 0.
neg  out  1  result[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled at the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, neg=0, slice counter=0, carry register=0.
- Reset mid-operation: the unit returns to IDLE on the next edge. It abandons the operation, emits no result and clears all outputs to their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, latch b (or ~b when op_sub=1) into operand registers.
  - Set carry register = op_sub, counter = 0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, the slice adds bits [k*SLICE +: SLICE] of the operands with the carry register.
  - The sum slice is written into result at the same position, and the carry register takes the slice carry out.
  - The counter increments each cycle.
  - On the cycle where counter == NSLICE-1: capture cout, ovf from the slice's MSB carry-in and carry-out, and zero/neg from the completed result. Go to DONE.
- DONE:
  - out_valid=1. result and flags are held stable while out_ready=0.
  - On out_ready=1: out_valid drops at the next edge and the FSM goes to IDLE. in_ready is high in the following cycle.
  - No input is accepted in DONE, so there is no overlap of consecutive operations.
- Latency:
  - Accept at edge T; out_valid is high from edge T+NSLICE.
  - Minimum issue interval is NSLICE+2 cycles (accept, NSLICE RUN cycles, one DONE cycle with out_ready=1).
- Degenerate case: WIDTH == SLICE gives NSLICE=1, a single RUN cycle.
- Intermediate output visibility: result bits for unprocessed slices are don't-care while out_valid=0. flags change only on the transition into DONE.
- Width rules: all arithmetic is unsigned modulo 2^WIDTH. Flags are computed on the full WIDTH-bit result only, never per slice.

Decomposition:
- Package (seq_cla_pkg): FSM state enum (IDLE, RUN, DONE) and a flags struct (cout, ovf, zero, neg).
- Sub-module cla_slice (combinational, parameter SLICE):
  - Computes per-bit generate and propagate signals and carry lookahead across the slice.
  - Outputs sum[SLICE], cout, and c_msb (carry into the top bit of the slice), used for ovf.
  - Instantiated once, with its inputs muxed by the slice counter.

Test Plan:
1. WIDTH=8: 0x7F + 0x01, op_sub=0 -> result=0x80, cout=0, ovf=1, neg=1, zero=0; out_valid exactly 2 cycles after accept.
2. 0x05 − 0x05 -> result=0x00, cout=1, ovf=0, zero=1, neg=0. Then 0x03 − 0x05 -> result=0xFE, cout=0 (borrow), ovf=0, neg=1.
3. 0xFF + 0x01 -> result=0x00, cout=1, ovf=0, zero=1. This checks carry propagation across the slice boundary.
4. Handshake:
   - Hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0.
   - Pulse in_valid with different operands during RUN and DONE -> ignored; the first result is unchanged.
   - out_ready=1 -> the next cycle, in_ready=1.
5. Reset: assert rst_n=0 for one edge while in RUN (after slice 0) -> next cycle state IDLE, out_valid=0, all outputs 0. A subsequent 0x10 + 0x20 -> 0x30 with correct flags.
6. WIDTH=16, SLICE=4: 0x8000 − 0x0001 -> result=0x7FFF, cout=1, ovf=1, neg=0; out_valid 4 cycles after accept.
